// File: rtl/page_seq_pkg.sv
// Shared constants and state encoding for the page-advance address sequencer.
package page_seq_pkg;

  localparam int ADDR_W = 16;
  localparam int PAGE_W = 8;
  localparam int PG_W   = ADDR_W - PAGE_W;

  localparam logic [PAGE_W-1:0] PAGE_END_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/page_advance.sv
// Combinational next-page address: bumps the page number, or reloads the
// restart address when the page number is already at its maximum.
module page_advance
  import page_seq_pkg::*;
(
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [ADDR_W-1:0] restart_addr,
  input  logic              enable,
  output logic [ADDR_W-1:0] next_addr,
  output logic              overflow
);

  logic [PG_W-1:0] page;

  assign page = cur_addr[ADDR_W-1:PAGE_W];

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    next_addr = cur_addr;
    overflow  = 1'b0;
    if (enable) begin
      if (page == '1) begin
        next_addr = restart_addr;
        overflow  = 1'b1;
      end else begin
        next_addr = {page + PG_W'(1), {PAGE_W{1'b0}}};
      end
    end
  end

endmodule

// File: rtl/page_seq_ctrl.sv
// Page-walking address sequencer with valid/ready output handshake.
// Optional abort input is enabled by defining PAGE_SEQ_ABORT_EN.
module page_seq_ctrl
  import page_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] restart_addr,
  input  logic [7:0]        num_pages,
  input  logic [8:0]        burst_len,
`ifdef PAGE_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done,
  output logic              wrapped
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] restart_q, restart_d;
  logic [8:0]        burst_q, burst_d;
  logic [8:0]        word_cnt_q, word_cnt_d;
  logic [7:0]        page_cnt_q, page_cnt_d;

  logic              abort_w;
  logic              hs;
  logic              page_end;
  logic [ADDR_W-1:0] adv_addr;
  logic              adv_ovf;

`ifdef PAGE_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  page_advance u_page_advance (
    .cur_addr     (addr_q),
    .restart_addr (restart_q),
    .enable       (state_q == ADV),
    .next_addr    (adv_addr),
    .overflow     (adv_ovf)
  );

  assign hs       = (state_q == RUN) && addr_ready;
  // Either the burst limit or the physical page boundary closes a page.
  assign page_end = ((word_cnt_q + 9'd1) == burst_q) ||
                    (addr_q[PAGE_W-1:0] == PAGE_END_OFF);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    restart_d  = restart_q;
    burst_d    = burst_q;
    word_cnt_d = word_cnt_q;
    page_cnt_d = page_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          restart_d  = restart_addr;
          burst_d    = (burst_len == 9'd0) ? 9'd256 : burst_len;
          word_cnt_d = 9'd0;
          page_cnt_d = num_pages;
          if (num_pages == 8'd0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            addr_d  = base_addr;
          end
        end
      end
      RUN: begin
        if (hs) begin
          if (page_end) begin
            page_cnt_d = page_cnt_q - 8'd1;
            state_d    = (page_cnt_q == 8'd1) ? DONE : ADV;
          end else begin
            addr_d     = {addr_q[ADDR_W-1:PAGE_W], addr_q[PAGE_W-1:0] + PAGE_W'(1)};
            word_cnt_d = word_cnt_q + 9'd1;
          end
        end
        if (abort_w) state_d = DONE;
      end
      ADV: begin
        word_cnt_d = 9'd0;
        if (abort_w) begin
          state_d = DONE;
        end else begin
          addr_d  = adv_addr;
          state_d = RUN;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      restart_q  <= '0;
      burst_q    <= '0;
      word_cnt_q <= '0;
      page_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      restart_q  <= restart_d;
      burst_q    <= burst_d;
      word_cnt_q <= word_cnt_d;
      page_cnt_q <= page_cnt_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign wrapped    = adv_ovf && !abort_w;

endmodule

// File: tb/tb_page_seq_ctrl.sv
// Self-checking bench for page_seq_ctrl: per-cycle directed tables, randomised-ready
// vector table with an address scoreboard, reset-abort and optional abort sequences.
module tb_page_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] restart_addr = '0;
  logic [7:0]  num_pages = '0;
  logic [8:0]  burst_len = '0;
  logic [15:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  logic        busy;
  logic        done;
  logic        wrapped;
`ifdef PAGE_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  logic rand_ready  = 1'b0;
  logic rnd_ready   = 1'b1;
  logic ready_force = 1'b1;
  assign addr_ready = rand_ready ? rnd_ready : ready_force;

  page_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .restart_addr (restart_addr),
    .num_pages    (num_pages),
    .burst_len    (burst_len),
`ifdef PAGE_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .addr         (addr),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .busy         (busy),
    .done         (done),
    .wrapped      (wrapped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected handshake addresses, filled by a behavioural walk model.
  logic [15:0] sb[$];
  int          hs_cnt, wrap_cnt, done_cnt, last_hs;
  logic        prev_stall;
  logic [15:0] prev_addr;

  task automatic mon_clear();
    sb.delete();
    hs_cnt = 0; wrap_cnt = 0; done_cnt = 0; last_hs = 0; prev_stall = 1'b0;
  endtask

  task automatic sb_push(input logic [15:0] base, input logic [15:0] rs,
                         input logic [7:0] pages, input logic [8:0] burst);
    logic [15:0] a;
    int          b, w;
    b = (burst == 9'd0) ? 256 : int'(burst);
    a = base;
    for (int p = 0; p < int'(pages); p++) begin
      w = 0;
      while (1) begin
        sb.push_back(a);
        w++;
        if (w == b || a[7:0] == 8'hFF) break;
        a[7:0] = a[7:0] + 8'd1;
      end
      if (p < int'(pages) - 1) begin
        if (a[15:8] == 8'hFF) a = rs;
        else a = {a[15:8] + 8'd1, 8'h00};
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor: scoreboard pops on handshakes, stall stability, done latency.
  initial begin
    logic [15:0] exp_a;
    mon_clear();
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", addr_valid, 1);
          check("stall_addr", addr, prev_addr);
        end
        if (addr_valid && addr_ready) begin
          if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
          else begin
            exp_a = sb.pop_front();
            check("sb_addr", addr, exp_a);
          end
          hs_cnt++;
          last_hs = cyc;
        end
        if (wrapped) wrap_cnt++;
        if (done) begin
          done_cnt++;
          if (hs_cnt > 0) check("done_latency", cyc, last_hs + 1);
        end
        prev_stall = addr_valid && !addr_ready;
        prev_addr  = addr;
      end
    end
  end

  typedef struct {
    logic        ready;
    logic        valid;
    logic        ca;
    logic [15:0] addr;
    logic        busy;
    logic        done;
    logic        wrapped;
  } cyc_exp_t;

  cyc_exp_t seq_q[$];

  task automatic add(input logic r, input logic v, input logic ca, input logic [15:0] a,
                     input logic b, input logic d, input logic w);
    cyc_exp_t e;
    e.ready = r; e.valid = v; e.ca = ca; e.addr = a; e.busy = b; e.done = d; e.wrapped = w;
    seq_q.push_back(e);
  endtask

  task automatic run_seq(input string tag, input logic [15:0] base, input logic [15:0] rs,
                         input logic [7:0] pages, input logic [8:0] burst);
    @(posedge clk); #1;
    mon_clear();
    sb_push(base, rs, pages, burst);
    base_addr = base; restart_addr = rs; num_pages = pages; burst_len = burst;
    rand_ready = 1'b0; ready_force = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < seq_q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      ready_force = seq_q[i].ready;
      @(negedge clk);
      check($sformatf("%s_valid[%0d]", tag, i), addr_valid, seq_q[i].valid);
      if (seq_q[i].ca) check($sformatf("%s_addr[%0d]", tag, i), addr, seq_q[i].addr);
      check($sformatf("%s_busy[%0d]", tag, i), busy, seq_q[i].busy);
      check($sformatf("%s_done[%0d]", tag, i), done, seq_q[i].done);
      check($sformatf("%s_wrapped[%0d]", tag, i), wrapped, seq_q[i].wrapped);
    end
    check($sformatf("%s_sb_empty", tag), sb.size(), 0);
    seq_q.delete();
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] rs;
    logic [7:0]  pages;
    logic [8:0]  burst;
    int          words;
    int          wraps;
    logic [15:0] last;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx);
    vec_t v;
    logic seen;
    v = vecs[idx];
    @(posedge clk); #1;
    mon_clear();
    sb_push(v.base, v.rs, v.pages, v.burst);
    base_addr = v.base; restart_addr = v.rs; num_pages = v.pages; burst_len = v.burst;
    rand_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check($sformatf("v%0d_done_seen", idx), seen, 1);
    @(negedge clk);
    @(negedge clk);
    check($sformatf("v%0d_sb_empty", idx), sb.size(), 0);
    check($sformatf("v%0d_words", idx), hs_cnt, v.words);
    check($sformatf("v%0d_wraps", idx), wrap_cnt, v.wraps);
    check($sformatf("v%0d_done_cnt", idx), done_cnt, 1);
    check($sformatf("v%0d_last_addr", idx), addr, v.last);
    check($sformatf("v%0d_idle", idx), busy, 0);
    rand_ready = 1'b0;
  endtask

  initial begin
    logic found;

    vecs[0] = '{16'h1200, 16'h0000, 8'd2, 9'd4,  8,   0, 16'h1303};
    vecs[1] = '{16'h12FE, 16'h0000, 8'd2, 9'd4,  6,   0, 16'h1303};
    vecs[2] = '{16'hFF00, 16'h0400, 8'd2, 9'd1,  2,   1, 16'h0400};
    vecs[3] = '{16'h0010, 16'h0000, 8'd1, 9'd0,  240, 0, 16'h00FF};
    vecs[4] = '{16'h3400, 16'h0000, 8'd1, 9'd0,  256, 0, 16'h34FF};
    vecs[5] = '{16'hFEF0, 16'hAB12, 8'd3, 9'd16, 48,  1, 16'hAB21};
    vecs[6] = '{16'h0500, 16'h0000, 8'd1, 9'd256, 256, 0, 16'h05FF};

    #2;
    check("rst_addr", addr, 16'h0000);
    check("rst_valid", addr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrapped", wrapped, 0);
    #21 rst = 1'b0;

    // Two full pages with a single bubble between them.
    for (int i = 0; i < 4; i++) add(1, 1, 1, 16'h1200 + 16'(i), 1, 0, 0);
    add(1, 0, 1, 16'h1203, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 1, 16'h1300 + 16'(i), 1, 0, 0);
    add(1, 0, 1, 16'h1303, 1, 1, 0);
    add(1, 0, 1, 16'h1303, 0, 0, 0);
    run_seq("two_pages", 16'h1200, 16'h0000, 8'd2, 9'd4);

    // Page-number overflow reloads the restart address.
    add(1, 1, 1, 16'hFF00, 1, 0, 0);
    add(1, 0, 1, 16'hFF00, 1, 0, 1);
    add(1, 1, 1, 16'h0400, 1, 0, 0);
    add(1, 0, 1, 16'h0400, 1, 1, 0);
    add(1, 0, 1, 16'h0400, 0, 0, 0);
    run_seq("wrap", 16'hFF00, 16'h0400, 8'd2, 9'd1);

    // Consumer stalls for three cycles on the second word.
    add(1, 1, 1, 16'h1200, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 16'h1201, 1, 0, 0);
    add(1, 1, 1, 16'h1201, 1, 0, 0);
    add(1, 0, 1, 16'h1201, 1, 1, 0);
    add(1, 0, 1, 16'h1201, 0, 0, 0);
    run_seq("stall", 16'h1200, 16'h0000, 8'd1, 9'd2);

    // Zero pages: straight to DONE, no addresses.
    add(1, 0, 0, 16'h0000, 1, 1, 0);
    add(1, 0, 0, 16'h0000, 0, 0, 0);
    run_seq("zero_pages", 16'h7777, 16'h0000, 8'd0, 9'd4);
    check("zero_pages_no_hs", hs_cnt, 0);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Asynchronous reset in the middle of the second page.
    @(posedge clk); #1;
    mon_clear();
    sb_push(16'h1200, 16'h0000, 8'd2, 9'd4);
    base_addr = 16'h1200; restart_addr = 16'h0000; num_pages = 8'd2; burst_len = 9'd4;
    rand_ready = 1'b0; ready_force = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (addr_valid && addr == 16'h1302) found = 1'b1;
    end
    check("midrst_reach", found, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_addr", addr, 16'h0000);
    check("midrst_valid", addr_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_wrapped", wrapped, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    #2 rst = 1'b0;
    run_vec(0);

`ifdef PAGE_SEQ_ABORT_EN
    @(posedge clk); #1;
    mon_clear();
    sb.push_back(16'h1300);
    sb.push_back(16'h1301);
    base_addr = 16'h1300; restart_addr = 16'h0000; num_pages = 8'd2; burst_len = 9'd4;
    rand_ready = 1'b0; ready_force = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (addr_valid && addr == 16'h1301) found = 1'b1;
    end
    check("abort_reach", found, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_done", done, 1);
    check("abort_valid", addr_valid, 0);
    repeat (4) @(negedge clk);
    check("abort_hs", hs_cnt, 2);
    check("abort_sb_empty", sb.size(), 0);
    check("abort_done_cnt", done_cnt, 1);
    check("abort_idle", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
